// File: rtl/mips_16_imem_loader_pkg.sv
// Shared types and constants for the MIPS16 instruction-memory loader.
package mips_16_imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_FILL,
    LDR_HOLD,
    LDR_RUN
  } loader_state_t;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  function automatic logic is_busy(input loader_state_t s);
    return (s == LDR_LOAD) || (s == LDR_FILL) || (s == LDR_HOLD);
  endfunction

endpackage

// File: rtl/mips_16_imem_loader_if.sv
// Bundle between the loader, its upstream word source, the imem write port
// and the core reset / status consumers.
interface mips_16_imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // Handshake: a word moves on a rising edge where in_valid and in_ready are both 1.
  // in_ready never depends on in_valid; in_data must be stable while in_valid is high.
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, num_words, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );

  modport slave (
    input  start, num_words, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/mips_16_imem_loader.sv
// Instruction-memory loader for the MIPS16 core: streams words into imem,
// optionally NOP-fills the remainder, then releases the core from reset.
module mips_16_imem_loader
  import mips_16_imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RST_HOLD  = 4,
  parameter bit FILL_REST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_16_imem_loader_if.slave  bus,
  output loader_state_t         o_dbg_state
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam int              HOLD_W = $clog2(RST_HOLD + 1);

  loader_state_t     r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_num;
  logic [HOLD_W-1:0] r_hold;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_can_start;

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_can_start = bus.start && ((r_state == LDR_IDLE) || (r_state == LDR_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LDR_IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
      r_hold  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LDR_IDLE, LDR_RUN: begin
          if (w_can_start) begin
            if (bus.num_words > DEPTH) begin
              r_err   <= 1'b1;
              r_state <= LDR_IDLE;
            end else begin
              r_err <= 1'b0;
              r_num <= bus.num_words;
              r_cnt <= '0;
              if (bus.num_words != '0) begin
                r_state <= LDR_LOAD;
              end else if (FILL_REST) begin
                r_state <= LDR_FILL;
              end else begin
                r_state <= LDR_HOLD;
                r_hold  <= HOLD_W'(RST_HOLD);
              end
            end
          end
        end
        LDR_LOAD: begin
          if (bus.in_valid) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[ADDR_W-1:0];
            r_wdata <= bus.in_data;
            r_cnt   <= w_cnt_inc;
            // A full-depth stream leaves nothing to fill.
            if (w_cnt_inc == r_num) begin
              if (FILL_REST && (r_num < DEPTH)) begin
                r_state <= LDR_FILL;
              end else begin
                r_state <= LDR_HOLD;
                r_hold  <= HOLD_W'(RST_HOLD);
              end
            end
          end
        end
        LDR_FILL: begin
          r_we    <= 1'b1;
          r_addr  <= r_cnt[ADDR_W-1:0];
          r_wdata <= DATA_W'(NOP_WORD);
          r_cnt   <= w_cnt_inc;
          if (r_cnt[ADDR_W-1:0] == '1) begin
            r_state <= LDR_HOLD;
            r_hold  <= HOLD_W'(RST_HOLD);
          end
        end
        LDR_HOLD: begin
          if (r_hold == HOLD_W'(1)) begin
            r_state <= LDR_RUN;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= LDR_IDLE;
      endcase
    end
  end

  // Status and core reset decode straight from the state register.
  assign bus.in_ready   = (r_state == LDR_LOAD);
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.core_rst   = (r_state != LDR_RUN);
  assign bus.busy       = is_busy(r_state);
  assign bus.done       = (r_state == LDR_RUN);
  assign bus.err        = r_err;
  assign o_dbg_state    = r_state;

endmodule
